// File: rtl/frontend_scheduler_mb_pkg.sv
// Shared types and helpers for the multi-bank frontend scheduler.
package frontend_scheduler_mb_pkg;

    typedef enum logic {
        CMD_READ  = 1'b0,
        CMD_WRITE = 1'b1
    } cmd_e;

    localparam int DEF_ROW_W = 14;
    localparam int DEF_COL_W = 10;
    localparam int DEF_TAG_W = 4;

    // Canonical queue entry at the default field widths.
    typedef struct packed {
        cmd_e                 cmd;
        logic [DEF_ROW_W-1:0] row;
        logic [DEF_COL_W-1:0] col;
        logic [DEF_TAG_W-1:0] tag;
    } sched_entry_t;

    // Bank index width; never narrower than one bit.
    function automatic int bank_idx_w(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

endpackage

// File: rtl/frontend_scheduler_mb_if.sv
// Request and issue channels of the frontend scheduler.
interface frontend_scheduler_mb_if
    import frontend_scheduler_mb_pkg::*;
#(
    parameter int NUM_BANKS = 8,
    parameter int ROW_W     = DEF_ROW_W,
    parameter int COL_W     = DEF_COL_W,
    parameter int TAG_W     = DEF_TAG_W
);
    localparam int BANK_W = bank_idx_w(NUM_BANKS);

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_cmd;
    logic [BANK_W-1:0]    req_bank;
    logic [ROW_W-1:0]     req_row;
    logic [COL_W-1:0]     req_col;
    logic [TAG_W-1:0]     req_tag;

    logic                 iss_valid;
    logic                 iss_ready;
    logic                 iss_cmd;
    logic [BANK_W-1:0]    iss_bank;
    logic [ROW_W-1:0]     iss_row;
    logic [COL_W-1:0]     iss_col;
    logic [TAG_W-1:0]     iss_tag;
    logic                 iss_row_hit;

    logic [NUM_BANKS-1:0] bank_full;
    logic                 sched_idle;

    // Environment side: drives requests, consumes issues.
    modport master (
        output req_valid, req_cmd, req_bank, req_row, req_col, req_tag, iss_ready,
        input  req_ready, iss_valid, iss_cmd, iss_bank, iss_row, iss_col, iss_tag,
        input  iss_row_hit, bank_full, sched_idle
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_cmd, req_bank, req_row, req_col, req_tag, iss_ready,
        output req_ready, iss_valid, iss_cmd, iss_bank, iss_row, iss_col, iss_tag,
        output iss_row_hit, bank_full, sched_idle
    );

endinterface

// File: rtl/frontend_scheduler_mb_fifo.sv
// Per-bank command queue: head-visible FIFO with wrap-bit pointers.
module frontend_scheduler_mb_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign head_o  = mem_q[rd_ptr_q[IDX_W-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer advance on accepted push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers; reset empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= din_i;
    end

endmodule

// File: rtl/frontend_scheduler_mb.sv
// Multi-bank frontend scheduler: per-bank queues, starvation / row-hit /
// round-robin arbitration, and a single issue register toward the backend.
module frontend_scheduler_mb
    import frontend_scheduler_mb_pkg::*;
#(
    parameter int NUM_BANKS     = 8,
    parameter int QUEUE_DEPTH   = 4,
    parameter int ROW_W         = DEF_ROW_W,
    parameter int COL_W         = DEF_COL_W,
    parameter int TAG_W         = DEF_TAG_W,
    parameter int AGE_W         = 8,
    parameter int AGE_LIMIT     = 200,
    parameter int ROW_HIT_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    frontend_scheduler_mb_if.slave bus
);
    localparam int BANK_W = bank_idx_w(NUM_BANKS);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    localparam logic [AGE_W-1:0] AGE_THR = AGE_W'(AGE_LIMIT);

    typedef struct packed {
        cmd_e             cmd;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t               push_entry;
    entry_t               head [NUM_BANKS];
    logic [NUM_BANKS-1:0] empty, full, push, pop;
    logic [NUM_BANKS-1:0] starve, hit, cls_mask;
    logic                 load, stall, found;
    logic [BANK_W-1:0]    sel_bank, cand;

    logic [NUM_BANKS-1:0] open_vld_q;
    logic [ROW_W-1:0]     open_row_q [NUM_BANKS];
    logic [AGE_W-1:0]     age_q [NUM_BANKS];
    logic [AGE_W-1:0]     age_d [NUM_BANKS];
    logic [BANK_W-1:0]    rr_q;

    logic                 iss_valid_q, iss_valid_d;
    logic                 iss_hit_q, iss_hit_d;
    logic [BANK_W-1:0]    iss_bank_q, iss_bank_d;
    entry_t               iss_q, iss_d;

    assign push_entry = '{cmd: cmd_e'(bus.req_cmd), row: bus.req_row,
                          col: bus.req_col, tag: bus.req_tag};

    // A full bank stays not-ready even when it is being popped this cycle.
    assign bus.req_ready = !full[bus.req_bank];

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        assign push[g] = bus.req_valid && bus.req_ready && (bus.req_bank == BANK_W'(g));
        assign pop[g]  = load && (sel_bank == BANK_W'(g));

        frontend_scheduler_mb_fifo #(
            .WIDTH ($bits(entry_t)),
            .DEPTH (QUEUE_DEPTH)
        ) u_queue (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[g]),
            .din_i   (push_entry),
            .pop_i   (pop[g]),
            .head_o  (head[g]),
            .empty_o (empty[g]),
            .full_o  (full[g])
        );
    end

    assign stall = iss_valid_q && !bus.iss_ready;
    assign load  = (|(~empty)) && !stall;

    // Classify heads, pick the highest non-empty class, then search from rr_q.
    always_comb begin
        starve   = '0;
        hit      = '0;
        cls_mask = '0;
        sel_bank = '0;
        cand     = '0;
        found    = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            starve[b] = !empty[b] && (age_q[b] >= AGE_THR);
            hit[b]    = !empty[b] && open_vld_q[b] && (head[b].row == open_row_q[b]);
        end
        if (|starve)                            cls_mask = starve;
        else if ((ROW_HIT_FIRST != 0) && (|hit)) cls_mask = hit;
        else                                    cls_mask = ~empty;
        for (int k = 0; k < NUM_BANKS; k++) begin
            cand = rr_q + BANK_W'(k);
            if (!found && cls_mask[cand]) begin
                found    = 1'b1;
                sel_bank = cand;
            end
        end
    end

    // Head ages: cleared on pop or empty, otherwise count cycles spent waiting.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            age_d[b] = age_q[b];
            if (empty[b] || pop[b])
                age_d[b] = '0;
            else if ((load || stall) && (age_q[b] != AGE_MAX))
                age_d[b] = age_q[b] + 1'b1;
        end
    end

    // Issue register next state; row-hit uses the open row before this load.
    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_d       = iss_q;
        iss_bank_d  = iss_bank_q;
        iss_hit_d   = iss_hit_q;
        if (load) begin
            iss_valid_d = 1'b1;
            iss_d       = head[sel_bank];
            iss_bank_d  = sel_bank;
            iss_hit_d   = hit[sel_bank];
        end else if (bus.iss_ready) begin
            iss_valid_d = 1'b0;
        end
    end

    // Scheduler state: issue register, open-row table, ages, rr pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid_q <= 1'b0;
            iss_q       <= '0;
            iss_bank_q  <= '0;
            iss_hit_q   <= 1'b0;
            rr_q        <= '0;
            open_vld_q  <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                open_row_q[b] <= '0;
                age_q[b]      <= '0;
            end
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_q       <= iss_d;
            iss_bank_q  <= iss_bank_d;
            iss_hit_q   <= iss_hit_d;
            for (int b = 0; b < NUM_BANKS; b++) age_q[b] <= age_d[b];
            if (load) begin
                rr_q                 <= sel_bank + 1'b1;
                open_row_q[sel_bank] <= head[sel_bank].row;
                open_vld_q[sel_bank] <= 1'b1;
            end
        end
    end

    assign bus.iss_valid   = iss_valid_q;
    assign bus.iss_cmd     = iss_q.cmd;
    assign bus.iss_bank    = iss_bank_q;
    assign bus.iss_row     = iss_q.row;
    assign bus.iss_col     = iss_q.col;
    assign bus.iss_tag     = iss_q.tag;
    assign bus.iss_row_hit = iss_hit_q;
    assign bus.bank_full   = full;
    assign bus.sched_idle  = (&empty) && !iss_valid_q;

endmodule

// File: tb/tb_frontend_scheduler_mb.sv
// Bench for frontend_scheduler_mb: instance A (AGE_LIMIT=4, row-hit-first)
// and instance B (AGE_LIMIT=200, pure round-robin), checked every cycle
// against a queue-level model plus directed literal expectations.
module tb_frontend_scheduler_mb;
    import frontend_scheduler_mb_pkg::*;

    localparam int NB = 8;
    localparam int QD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    frontend_scheduler_mb_if #(.NUM_BANKS(NB), .ROW_W(14), .COL_W(10), .TAG_W(4)) bus_a ();
    frontend_scheduler_mb_if #(.NUM_BANKS(NB), .ROW_W(14), .COL_W(10), .TAG_W(4)) bus_b ();

    frontend_scheduler_mb #(
        .NUM_BANKS(NB), .QUEUE_DEPTH(QD), .ROW_W(14), .COL_W(10), .TAG_W(4),
        .AGE_W(8), .AGE_LIMIT(4), .ROW_HIT_FIRST(1)
    ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    frontend_scheduler_mb #(
        .NUM_BANKS(NB), .QUEUE_DEPTH(QD), .ROW_W(14), .COL_W(10), .TAG_W(4),
        .AGE_W(8), .AGE_LIMIT(200), .ROW_HIT_FIRST(0)
    ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // ---------------- model ----------------
    sched_entry_t mq   [2][NB][QD];
    int           mcnt [2][NB];
    logic [13:0]  mopen[2][NB];
    bit           mopv [2][NB];
    int           mage [2][NB];
    int           mrr  [2];
    bit           miv  [2];
    sched_entry_t mis  [2];
    int           mib  [2];
    bit           mhit [2];

    function automatic int lim(input int i);
        return (i == 0) ? 4 : 200;
    endfunction

    function automatic bit rhf(input int i);
        return (i == 0);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            mrr[i] = 0; miv[i] = 0; mis[i] = '0; mib[i] = 0; mhit[i] = 0;
            for (int b = 0; b < NB; b++) begin
                mcnt[i][b] = 0; mopen[i][b] = '0; mopv[i][b] = 0; mage[i][b] = 0;
            end
        end
    endtask

    function automatic int m_pick(input int i);
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < NB; k++) begin
                int b;
                b = (mrr[i] + k) % NB;
                if (mcnt[i][b] > 0) begin
                    if (c == 0 && mage[i][b] >= lim(i)) return b;
                    if (c == 1 && rhf(i) && mopv[i][b] && mopen[i][b] == mq[i][b][0].row) return b;
                    if (c == 2) return b;
                end
            end
        end
        return -1;
    endfunction

    task automatic m_step(input int i, input bit rv, input int rb, input sched_entry_t re, input bit ir);
        bit any, load, stall, acc;
        int sel;
        int nage [NB];
        any = 0;
        for (int b = 0; b < NB; b++) if (mcnt[i][b] > 0) any = 1;
        stall = miv[i] && !ir;
        load  = any && !stall;
        sel   = load ? m_pick(i) : -1;
        acc   = rv && (mcnt[i][rb] < QD);
        for (int b = 0; b < NB; b++) begin
            if (mcnt[i][b] == 0 || b == sel) nage[b] = 0;
            else if (load || stall)          nage[b] = (mage[i][b] < 255) ? mage[i][b] + 1 : 255;
            else                             nage[b] = mage[i][b];
        end
        if (load) begin
            mis[i]  = mq[i][sel][0];
            mib[i]  = sel;
            mhit[i] = mopv[i][sel] && (mopen[i][sel] == mq[i][sel][0].row);
            miv[i]  = 1;
            mopen[i][sel] = mq[i][sel][0].row;
            mopv[i][sel]  = 1;
            mrr[i] = (sel + 1) % NB;
            for (int j = 0; j < QD - 1; j++) mq[i][sel][j] = mq[i][sel][j+1];
            mcnt[i][sel]--;
        end else if (ir) begin
            miv[i] = 0;
        end
        if (acc) begin
            mq[i][rb][mcnt[i][rb]] = re;
            mcnt[i][rb]++;
        end
        for (int b = 0; b < NB; b++) mage[i][b] = nage[b];
    endtask

    function automatic sched_entry_t mk(input logic c, input logic [13:0] r, input logic [9:0] co, input logic [3:0] t);
        sched_entry_t e;
        e.cmd = cmd_e'(c); e.row = r; e.col = co; e.tag = t;
        return e;
    endfunction

    // Model advances on the same edge as the DUTs; reset clears it.
    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else begin
            m_step(0, bus_a.req_valid, int'(bus_a.req_bank),
                   mk(bus_a.req_cmd, bus_a.req_row, bus_a.req_col, bus_a.req_tag), bus_a.iss_ready);
            m_step(1, bus_b.req_valid, int'(bus_b.req_bank),
                   mk(bus_b.req_cmd, bus_b.req_row, bus_b.req_col, bus_b.req_tag), bus_b.iss_ready);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input int i, input string p, input logic iv, input logic cmd,
                       input logic [2:0] bank, input logic [13:0] row, input logic [9:0] col,
                       input logic [3:0] tag, input logic hit, input logic [7:0] full,
                       input logic idle, input logic rdy, input logic [2:0] rbank);
        logic [7:0] efull;
        bit eidle;
        eidle = !miv[i];
        for (int b = 0; b < NB; b++) begin
            efull[b] = (mcnt[i][b] == QD);
            if (mcnt[i][b] != 0) eidle = 0;
        end
        chk({p, ".iss_valid"}, 32'(iv), 32'(miv[i]));
        if (miv[i]) begin
            chk({p, ".iss_cmd"},  32'(cmd),  32'(mis[i].cmd));
            chk({p, ".iss_bank"}, 32'(bank), 32'(mib[i]));
            chk({p, ".iss_row"},  32'(row),  32'(mis[i].row));
            chk({p, ".iss_col"},  32'(col),  32'(mis[i].col));
            chk({p, ".iss_tag"},  32'(tag),  32'(mis[i].tag));
            chk({p, ".iss_row_hit"}, 32'(hit), 32'(mhit[i]));
        end
        chk({p, ".bank_full"},  32'(full), 32'(efull));
        chk({p, ".sched_idle"}, 32'(idle), 32'(eidle));
        chk({p, ".req_ready"},  32'(rdy),  32'(mcnt[i][rbank] < QD));
    endtask

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, "a", bus_a.iss_valid, bus_a.iss_cmd, bus_a.iss_bank, bus_a.iss_row, bus_a.iss_col,
                bus_a.iss_tag, bus_a.iss_row_hit, bus_a.bank_full, bus_a.sched_idle,
                bus_a.req_ready, bus_a.req_bank);
            cmp(1, "b", bus_b.iss_valid, bus_b.iss_cmd, bus_b.iss_bank, bus_b.iss_row, bus_b.iss_col,
                bus_b.iss_tag, bus_b.iss_row_hit, bus_b.bank_full, bus_b.sched_idle,
                bus_b.req_ready, bus_b.req_bank);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input int bank, input logic [13:0] row, input logic [9:0] col,
                          input logic [3:0] tag, input logic cmd);
        bus_a.req_valid = 1'b1; bus_a.req_bank = 3'(bank); bus_a.req_row = row;
        bus_a.req_col = col; bus_a.req_tag = tag; bus_a.req_cmd = cmd;
        tick();
        bus_a.req_valid = 1'b0;
    endtask

    task automatic send_b(input int bank, input logic [13:0] row, input logic [9:0] col,
                          input logic [3:0] tag, input logic cmd);
        bus_b.req_valid = 1'b1; bus_b.req_bank = 3'(bank); bus_b.req_row = row;
        bus_b.req_col = col; bus_b.req_tag = tag; bus_b.req_cmd = cmd;
        tick();
        bus_b.req_valid = 1'b0;
    endtask

    task automatic drain_a(input int budget);
        bus_a.iss_ready = 1'b1;
        for (int k = 0; k < budget && !bus_a.sched_idle; k++) tick();
        chk("a.drain_idle", 32'(bus_a.sched_idle), 32'd1);
    endtask

    task automatic drain_b(input int budget);
        bus_b.iss_ready = 1'b1;
        for (int k = 0; k < budget && !bus_b.sched_idle; k++) tick();
        chk("b.drain_idle", 32'(bus_b.sched_idle), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        bus_a.req_valid = 0; bus_a.req_cmd = 0; bus_a.req_bank = 0; bus_a.req_row = 0;
        bus_a.req_col = 0; bus_a.req_tag = 0; bus_a.iss_ready = 0;
        bus_b.req_valid = 0; bus_b.req_cmd = 0; bus_b.req_bank = 0; bus_b.req_row = 0;
        bus_b.req_col = 0; bus_b.req_tag = 0; bus_b.iss_ready = 0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        chk("reset.idle",      32'(bus_a.sched_idle), 32'd1);
        chk("reset.iss_valid", 32'(bus_a.iss_valid),  32'd0);
        chk("reset.bank_full", 32'(bus_a.bank_full),  32'd0);

        // Single read, then a repeat to the same row.
        bus_a.iss_ready = 1'b1;
        send_a(2, 14'h10, 10'h4, 4'd5, 1'b0);
        chk("single.latency_t", 32'(bus_a.iss_valid), 32'd0);
        tick();
        chk("single.valid", 32'(bus_a.iss_valid), 32'd1);
        chk("single.bank",  32'(bus_a.iss_bank),  32'd2);
        chk("single.row",   32'(bus_a.iss_row),   32'h10);
        chk("single.col",   32'(bus_a.iss_col),   32'h4);
        chk("single.tag",   32'(bus_a.iss_tag),   32'd5);
        chk("single.hit",   32'(bus_a.iss_row_hit), 32'd0);
        send_a(2, 14'h10, 10'h8, 4'd6, 1'b1);
        tick();
        chk("repeat.tag", 32'(bus_a.iss_tag),     32'd6);
        chk("repeat.hit", 32'(bus_a.iss_row_hit), 32'd1);
        tick();

        // Fill bank 3 behind a stalled issue register.
        bus_a.iss_ready = 1'b0;
        for (int k = 0; k < 5; k++) send_a(3, 14'(14'h100 + k), 10'(k), 4'(k), 1'b0);
        chk("full.bank3", 32'(bus_a.bank_full[3]), 32'd1);
        bus_a.req_bank = 3'd3; #1;
        chk("full.ready3", 32'(bus_a.req_ready), 32'd0);
        bus_a.req_bank = 3'd4; #1;
        chk("full.ready4", 32'(bus_a.req_ready), 32'd1);
        bus_a.iss_ready = 1'b1;
        tick();
        bus_a.iss_ready = 1'b0;
        bus_a.req_bank = 3'd3; #1;
        chk("full.ready3_after_pop", 32'(bus_a.req_ready), 32'd1);
        drain_a(40);

        // Row-hit preference over round-robin with rr_ptr at 0.
        send_a(0, 14'h20, 10'h0, 4'd0, 1'b0);
        send_a(1, 14'h30, 10'h0, 4'd1, 1'b0);
        send_a(7, 14'h77, 10'h0, 4'd7, 1'b0);
        tick();
        bus_a.iss_ready = 1'b0;
        send_a(0, 14'h21, 10'h1, 4'd8, 1'b0);
        send_a(1, 14'h30, 10'h1, 4'd9, 1'b0);
        bus_a.iss_ready = 1'b1;
        tick();
        chk("rowhit.first_bank", 32'(bus_a.iss_bank),    32'd1);
        chk("rowhit.first_hit",  32'(bus_a.iss_row_hit), 32'd1);
        tick();
        chk("rowhit.second_bank", 32'(bus_a.iss_bank),    32'd0);
        chk("rowhit.second_hit",  32'(bus_a.iss_row_hit), 32'd0);
        drain_a(40);

        // Starvation: bank 0 misses while banks 1 and 2 keep hitting.
        bus_a.iss_ready = 1'b0;
        send_a(2, 14'h40, 10'h0, 4'd2, 1'b0);
        for (int k = 0; k < 4; k++) send_a(1, 14'h30, 10'(k), 4'd1, 1'b0);
        for (int k = 0; k < 4; k++) send_a(2, 14'h40, 10'(k), 4'd2, 1'b0);
        bus_a.iss_ready = 1'b1;
        send_a(0, 14'h55, 10'h3, 4'd15, 1'b1);
        seen = 99;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (seen == 99 && bus_a.iss_valid && bus_a.iss_bank == 3'd0) seen = k;
        end
        chk("starve.within_5", 32'(seen <= 5), 32'd1);
        drain_a(40);

        // Pure round-robin on instance B, including a would-be row hit.
        bus_b.iss_ready = 1'b0;
        send_b(7, 14'h7, 10'h0, 4'd0, 1'b0);
        for (int k = 0; k < NB; k++) send_b(k, (k == 7) ? 14'h7 : 14'(14'h100 + k), 10'(k), 4'(k), 1'b0);
        send_b(0, 14'h200, 10'h0, 4'd0, 1'b1);
        bus_b.iss_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk($sformatf("rr.order%0d", k), 32'(bus_b.iss_bank), 32'(k % NB));
        end
        drain_b(40);

        // Asynchronous reset mid-stream: three queued, one issued.
        bus_a.iss_ready = 1'b0;
        send_a(1, 14'h1, 10'h0, 4'd1, 1'b0);
        send_a(2, 14'h2, 10'h0, 4'd2, 1'b0);
        send_a(3, 14'h3, 10'h0, 4'd3, 1'b0);
        send_a(4, 14'h4, 10'h0, 4'd4, 1'b0);
        chk("midrst.pre_valid", 32'(bus_a.iss_valid), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("midrst.iss_valid", 32'(bus_a.iss_valid),  32'd0);
        chk("midrst.idle",      32'(bus_a.sched_idle), 32'd1);
        chk("midrst.bank_full", 32'(bus_a.bank_full),  32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus_a.iss_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("midrst.no_stale%0d", k), 32'(bus_a.iss_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
